// File: rtl/stream_pkg.sv
// Shared definitions for the stream demultiplexer: FSM encodings, counter width, default sizes.
package stream_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int CNT_W    = 16;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 4;
  localparam int DEF_SELW  = 2;

endpackage

// File: rtl/demux_onehot.sv
// SELW-to-N one-hot decoder with an enable; all-zero output when disabled.
module demux_onehot #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0] sel_i,
  input  logic            en_i,
  output logic [N-1:0]    onehot_o
);

  // NOTE: default first so every path assigns onehot_o and no latch is inferred.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux: one-entry buffer steering a word to the lane named by its select.
// Optional per-channel drain counters (cnt_clr, cnt_flat) when STREAM_DEMUX_CNT_EN is defined.
module stream_demux
  import stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,     // must equal 2**SELW
  parameter int SELW  = DEF_SELW
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef STREAM_DEMUX_CNT_EN
  input  logic             cnt_clr,
  output logic [N*CNT_W-1:0] cnt_flat,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             drain, accept;

  assign busy     = (state_q == ST_FULL);
  assign drain    = busy && out_ready[sel_q];
  assign in_ready = !busy || drain;
  assign accept   = in_valid && in_ready;
  assign out_data = data_q;

  demux_onehot #(.N(N), .SELW(SELW)) u_dec (
    .sel_i    (sel_q),
    .en_i     (busy),
    .onehot_o (out_valid)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          data_d  = in_data;
          sel_d   = in_sel;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // accept here implies drain, so a reload keeps 1 word/clk throughput
        if (accept) begin
          data_d = in_data;
          sel_d  = in_sel;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [N-1:0]     drain_vec;
  logic [CNT_W-1:0] cnt_q [N];

  // the decoded valid gated by each lane's ready is exactly the per-channel drain strobe
  assign drain_vec = out_valid & out_ready;

  // NOTE: the counter array is small register state, so it is reset element by element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (cnt_clr)           cnt_q[k] <= '0;
        else if (drain_vec[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: queue-based reference model compared every cycle plus directed literal checks.
module tb_stream_demux;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [SELW-1:0]  in_sel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready = '0;
  logic             busy;
`ifdef STREAM_DEMUX_CNT_EN
  logic             cnt_clr = 1'b0;
  logic [N*16-1:0]  cnt_flat;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  stream_demux #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef STREAM_DEMUX_CNT_EN
    .cnt_clr   (cnt_clr),
    .cnt_flat  (cnt_flat),
`endif
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the in-flight words as a queue (never more than one entry).
  typedef struct {
    logic [WIDTH-1:0] data;
    int               sel;
  } word_t;

  word_t       held[$];
  logic [WIDTH-1:0] last_data = '0;
  int          cnt_m [N];

  function automatic logic m_in_ready();
    return (held.size() == 0) || out_ready[held[0].sel];
  endfunction

  initial begin
    for (int k = 0; k < N; k++) cnt_m[k] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        held.delete();
        last_data = '0;
        for (int k = 0; k < N; k++) cnt_m[k] = 0;
      end else begin
        logic  can_take;
        word_t w;
        can_take = m_in_ready();
`ifdef STREAM_DEMUX_CNT_EN
        if (cnt_clr) for (int k = 0; k < N; k++) cnt_m[k] = 0;
        else if (held.size() != 0 && out_ready[held[0].sel])
          cnt_m[held[0].sel] = (cnt_m[held[0].sel] + 1) % 65536;
`endif
        if (held.size() != 0 && out_ready[held[0].sel]) void'(held.pop_front());
        if (in_valid && can_take) begin
          w.data = in_data;
          w.sel  = int'(in_sel);
          held.push_back(w);
          last_data = in_data;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic [N-1:0] ev;
        ev = (held.size() != 0) ? (N'(1) << held[0].sel) : '0;
        check("cyc_out_valid", 64'(out_valid), 64'(ev));
        check("cyc_busy",      64'(busy),      64'(held.size() != 0));
        check("cyc_in_ready",  64'(in_ready),  64'(m_in_ready()));
        // data_q is kept after drain, so out_data always equals the last accepted word
        check("cyc_out_data",  64'(out_data),  64'(last_data));
`ifdef STREAM_DEMUX_CNT_EN
        for (int k = 0; k < N; k++)
          check("cyc_cnt", 64'(cnt_flat[k*16 +: 16]), 64'(cnt_m[k]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SELW-1:0] s,
                       input logic [N-1:0] rdy);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = rdy;
  endtask

  initial begin
    logic [7:0]  wd [4];
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;

    // reset and idle
    repeat (3) tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_busy",      64'(busy),      64'h0);
    check("rst_in_ready",  64'(in_ready),  64'h1);
    check("rst_out_data",  64'(out_data),  64'h00);

    // single word to lane 2
    drive(1'b1, 8'hA5, 2'd2, 4'b1111);
    tick();
    drive(1'b0, 8'h00, 2'd0, 4'b1111);
    check("single_valid", 64'(out_valid), 64'b0100);
    check("single_data",  64'(out_data),  64'hA5);
    tick();
    check("single_busy_after", 64'(busy), 64'h0);

    // back-to-back streaming across all lanes
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, wd[i], SELW'(i), 4'b1111);
      check("stream_in_ready", 64'(in_ready), 64'h1);
      tick();
      check("stream_valid", 64'(out_valid), 64'(4'b0001 << i));
      check("stream_data",  64'(out_data),  64'(wd[i]));
    end
    drive(1'b0, 8'h00, 2'd0, 4'b1111);
    tick();

    // back-pressure on lane 1; other lanes' ready must be ignored
    drive(1'b1, 8'h3C, 2'd1, 4'b1101);
    tick();
    drive(1'b1, 8'h5A, 2'd3, 4'b1101);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",    64'(out_valid), 64'b0010);
      check("bp_in_ready", 64'(in_ready),  64'h0);
      check("bp_data",     64'(out_data),  64'h3C);
      tick();
    end
    out_ready = 4'b1111;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'h1);
    tick();
    drive(1'b0, 8'h00, 2'd0, 4'b1111);
    check("bp_next_valid", 64'(out_valid), 64'b1000);
    check("bp_next_data",  64'(out_data),  64'h5A);
    tick();

    // asynchronous reset while a word is stalled
    drive(1'b1, 8'h77, 2'd0, 4'b1110);
    tick();
    in_valid = 1'b0;
    check("rst_mid_full", 64'(out_valid), 64'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async_valid", 64'(out_valid), 64'h0);
    check("rst_mid_async_busy",  64'(busy),      64'h0);
    tick();
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_no_word", 64'(out_valid), 64'h0);
    end

`ifdef STREAM_DEMUX_CNT_EN
    // 3 drains to lane 0, 1 to lane 3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h90 + i), (i == 3) ? 2'd3 : 2'd0, 4'b1111);
      tick();
    end
    drive(1'b0, 8'h00, 2'd0, 4'b1111);
    tick();
    check("cnt_ch0", 64'(cnt_flat[15:0]),  64'd3);
    check("cnt_ch1", 64'(cnt_flat[31:16]), 64'd0);
    check("cnt_ch2", 64'(cnt_flat[47:32]), 64'd0);
    check("cnt_ch3", 64'(cnt_flat[63:48]), 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr_all", 64'(cnt_flat), 64'h0);

    // 65535 drains to lane 2, then one more wraps to zero
    drive(1'b1, 8'hEE, 2'd2, 4'b1111);
    repeat (65535) tick();
    in_valid = 1'b0;
    tick();
    check("cnt_ffff", 64'(cnt_flat[47:32]), 64'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("cnt_wrap", 64'(cnt_flat[47:32]), 64'h0);
`endif

    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
